// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 16;
    localparam int DEFAULT_PC_IDX   = DEFAULT_NUM_REGS - 1;
    localparam int DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit tracking for in-flight producers, with an incrementally maintained
// count of outstanding registers. A set and a clear of the same register in
// one cycle leave it busy (the newer producer wins).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS = DEFAULT_NUM_REGS,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic [ADDR_W:0]     count
);

    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_q;
    logic [ADDR_W:0]     count_d;
    logic [ADDR_W:0]     count_q;
    logic                rise_s;
    logic                fall_s;

    // Next busy vector and count: clear first so a same-address set overrides it.
    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        rise_s  = set_en && !busy_q[set_addr];
        fall_s  = clr_en && busy_q[clr_addr] && !(set_en && (set_addr == clr_addr));
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end else begin
            busy_d[set_addr] = busy_d[set_addr];
        end
        case ({rise_s, fall_s})
            2'b10:   count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{ADDR_W{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= {NUM_REGS{1'b0}};
            count_q <= {(ADDR_W+1){1'b0}};
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy  = busy_q;
    assign count = count_q;

endmodule

// File: rtl/scoreboard_register_file.sv
// Two-read, one-write register file with a PC alias slot and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module scoreboard_register_file
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DEFAULT_DATA_W,
    parameter  int NUM_REGS = DEFAULT_NUM_REGS,
    parameter  int PC_IDX   = NUM_REGS - 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              mark,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    output logic              stall,
    output logic [ADDR_W:0]   busy_count
);

    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0]   rf_d [NUM_REGS];
    logic [DATA_W-1:0]   rf_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_vec_s;
    logic                wr_ok_s;
    logic                mark_ok_s;

    assign wr_ok_s   = we && (wa != PC_ADDR);
    assign mark_ok_s = mark && (mark_addr != PC_ADDR);

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (mark_ok_s),
        .set_addr (mark_addr),
        .clr_en   (wr_ok_s),
        .clr_addr (wa),
        .busy     (busy_vec_s),
        .count    (busy_count)
    );

    // Storage next state: the PC slot is never written.
    always_comb begin
        rf_d = rf_q;
        if (wr_ok_s) begin
            rf_d[wa] = wd;
        end else begin
            rf_d = rf_q;
        end
    end

    // Storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q <= '{default: {DATA_W{1'b0}}};
        end else begin
            rf_q <= rf_d;
        end
    end

    // Read port 1: PC alias, optional forwarding, then storage.
    always_comb begin
        rd1   = rf_q[ra1];
        busy1 = busy_vec_s[ra1];
        if (ra1 == PC_ADDR) begin
            rd1   = pc_in;
            busy1 = 1'b0;
`ifdef REGFILE_BYPASS_EN
        end else if (wr_ok_s && !rst && (wa == ra1)) begin
            rd1   = wd;
            busy1 = 1'b0;
`endif
        end else begin
            rd1   = rf_q[ra1];
            busy1 = busy_vec_s[ra1];
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rd2   = rf_q[ra2];
        busy2 = busy_vec_s[ra2];
        if (ra2 == PC_ADDR) begin
            rd2   = pc_in;
            busy2 = 1'b0;
`ifdef REGFILE_BYPASS_EN
        end else if (wr_ok_s && !rst && (wa == ra2)) begin
            rd2   = wd;
            busy2 = 1'b0;
`endif
        end else begin
            rd2   = rf_q[ra2];
            busy2 = busy_vec_s[ra2];
        end
    end

    assign stall = busy1 || busy2;

endmodule
